// File: rtl/multi_sel_mode_ctrl_pkg.sv
// Shared types, defaults and width helper for the per-channel mode/digit selector.
package multi_sel_mode_ctrl_pkg;

  localparam int NCH_DEF     = 4;
  localparam int NSTATE_DEF  = 2;
  localparam int SW_SYNC_DEF = 2;

  // Ceiling log2, but never below one bit so single-entry fields stay legal.
  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  localparam int CH_W_DEF = clog2_min1(NCH_DEF);

  typedef logic [CH_W_DEF-1:0] ch_idx_t;

  typedef enum logic {
    ARMING = 1'b0,
    ARMED  = 1'b1
  } arm_state_t;

endpackage

// File: rtl/multi_sel_mode_ctrl_if.sv
// Switch/PC command inputs and selection outputs of the mode selector.
interface multi_sel_mode_ctrl_if
  import multi_sel_mode_ctrl_pkg::*;
#(
  parameter int NCH    = NCH_DEF,
  parameter int NSTATE = NSTATE_DEF
);
  localparam int W   = clog2_min1(NSTATE);
  localparam int CHW = clog2_min1(NCH);

  logic [NCH-1:0]   i_sw_lvl;
  logic [NCH-1:0]   i_pc_step;
  logic             i_pc_load;
  logic [CHW-1:0]   i_pc_ch;
  logic [W-1:0]     i_pc_val;
  logic [NCH-1:0]   i_lock;
  logic [NCH*W-1:0] o_sel;
  logic [NCH-1:0]   o_chg;
  logic             o_load_err;

  modport master (
    output i_sw_lvl, i_pc_step, i_pc_load, i_pc_ch, i_pc_val, i_lock,
    input  o_sel, o_chg, o_load_err
  );

  modport slave (
    input  i_sw_lvl, i_pc_step, i_pc_load, i_pc_ch, i_pc_val, i_lock,
    output o_sel, o_chg, o_load_err
  );

endinterface

// File: rtl/multi_sel_mode_ctrl_sw_edge_sync.sv
// Synchronizes one slide-switch level and emits a registered pulse on either edge,
// suppressed while the block is not yet armed after reset.
module multi_sel_mode_ctrl_sw_edge_sync #(
  parameter int SW_SYNC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_lvl,
  input  logic i_arm,
  output logic o_evt
);

  logic [SW_SYNC-1:0] r_sync;
  logic               r_dly;
  logic               r_evt;
  logic               w_edge;

  assign w_edge = r_sync[SW_SYNC-1] ^ r_dly;

  // Delay flop keeps following the level even while masked, so no stale edge survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_dly  <= 1'b0;
      r_evt  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SW_SYNC-2:0], i_lvl};
      r_dly  <= r_sync[SW_SYNC-1];
      r_evt  <= w_edge & i_arm;
    end
  end

  assign o_evt = r_evt;

endmodule

// File: rtl/multi_sel_mode_ctrl.sv
// Per-channel wrapping selection index driven by slide switches and PC commands,
// with post-reset arming, per-channel lock, direct load and change strobes.
module multi_sel_mode_ctrl
  import multi_sel_mode_ctrl_pkg::*;
#(
  parameter int NCH     = NCH_DEF,
  parameter int NSTATE  = NSTATE_DEF,
  parameter int SW_SYNC = SW_SYNC_DEF
) (
  input logic                  clk,
  input logic                  rst,
  multi_sel_mode_ctrl_if.slave s_if
);

  localparam int W     = clog2_min1(NSTATE);
  localparam int ARM_N = SW_SYNC + 1;
  localparam int CNT_W = clog2_min1(ARM_N);

  arm_state_t       r_state;
  arm_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_arm_cnt;
  logic [CNT_W-1:0] w_arm_cnt_nxt;
  logic             w_armed;

  logic [NCH-1:0]   w_sw_evt;
  logic [NCH-1:0]   r_step;
  logic [NCH-1:0]   w_evt;
  logic             w_load_ok;

  logic [NCH*W-1:0] r_sel;
  logic [NCH*W-1:0] w_sel_nxt;
  logic [NCH-1:0]   r_chg;
  logic [NCH-1:0]   w_chg_nxt;
  logic             r_err;

  function automatic logic [W-1:0] adv_idx(input logic [W-1:0] v);
    return (v == W'(NSTATE - 1)) ? '0 : v + W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ARMING;
      r_arm_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_arm_cnt <= w_arm_cnt_nxt;
    end
  end

  // Edges seen during the first SW_SYNC+1 cycles reflect the reset-time level, not a user action.
  always_comb begin
    w_state_nxt   = r_state;
    w_arm_cnt_nxt = r_arm_cnt;
    case (r_state)
      ARMING: begin
        if (r_arm_cnt == CNT_W'(ARM_N - 1)) w_state_nxt = ARMED;
        else                                w_arm_cnt_nxt = r_arm_cnt + CNT_W'(1);
      end
      ARMED:   w_state_nxt = ARMED;
      default: w_state_nxt = ARMING;
    endcase
  end

  assign w_armed = (r_state == ARMED);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    multi_sel_mode_ctrl_sw_edge_sync #(
      .SW_SYNC (SW_SYNC)
    ) u_sw_sync (
      .clk   (clk),
      .rst   (rst),
      .i_lvl (s_if.i_sw_lvl[g]),
      .i_arm (w_armed),
      .o_evt (w_sw_evt[g])
    );
  end

  assign w_evt     = (w_sw_evt | r_step) & ~s_if.i_lock;
  assign w_load_ok = s_if.i_pc_load && (int'(s_if.i_pc_ch) < NCH)
                     && (int'(s_if.i_pc_val) < NSTATE);

  // A valid load wins over any event on its channel and ignores lock.
  always_comb begin
    w_sel_nxt = r_sel;
    w_chg_nxt = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_load_ok && (int'(s_if.i_pc_ch) == i)) begin
        w_sel_nxt[i*W +: W] = s_if.i_pc_val;
        w_chg_nxt[i]        = (s_if.i_pc_val != r_sel[i*W +: W]);
      end else if (w_evt[i]) begin
        w_sel_nxt[i*W +: W] = adv_idx(r_sel[i*W +: W]);
        w_chg_nxt[i]        = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step <= '0;
      r_sel  <= '0;
      r_chg  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_step <= s_if.i_pc_step;
      r_sel  <= w_sel_nxt;
      r_chg  <= w_chg_nxt;
      r_err  <= s_if.i_pc_load & ~w_load_ok;
    end
  end

  assign s_if.o_sel      = r_sel;
  assign s_if.o_chg      = r_chg;
  assign s_if.o_load_err = r_err;

endmodule

// File: tb/tb_multi_sel_mode_ctrl.sv
// Bench for the mode selector: three instances (NSTATE 2, 3, 4) share one stimulus
// stream and are scored cycle by cycle against an event-history reference model.
module tb_multi_sel_mode_ctrl;
  import multi_sel_mode_ctrl_pkg::*;

  localparam int SWS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw_lvl;
  logic [3:0] pc_step;
  logic [3:0] lock;
  logic       pc_load;
  ch_idx_t    pc_ch;
  logic [1:0] pc_val;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int sel[3];
    int chg[3];
    int err[3];
  } exp_t;

  exp_t       q[$];
  logic [3:0] sw_hist[$];
  logic [3:0] prev_step;
  int         msel[3][4];
  int         ns_tab[3] = '{2, 3, 4};
  int         w_tab[3]  = '{1, 2, 2};

  multi_sel_mode_ctrl_if #(.NCH(4), .NSTATE(2)) bus2 ();
  multi_sel_mode_ctrl_if #(.NCH(4), .NSTATE(3)) bus3 ();
  multi_sel_mode_ctrl_if #(.NCH(4), .NSTATE(4)) bus4 ();

  assign bus2.i_sw_lvl = sw_lvl;  assign bus3.i_sw_lvl = sw_lvl;  assign bus4.i_sw_lvl = sw_lvl;
  assign bus2.i_pc_step = pc_step; assign bus3.i_pc_step = pc_step; assign bus4.i_pc_step = pc_step;
  assign bus2.i_pc_load = pc_load; assign bus3.i_pc_load = pc_load; assign bus4.i_pc_load = pc_load;
  assign bus2.i_pc_ch = pc_ch;     assign bus3.i_pc_ch = pc_ch;     assign bus4.i_pc_ch = pc_ch;
  assign bus2.i_pc_val = pc_val[0]; assign bus3.i_pc_val = pc_val; assign bus4.i_pc_val = pc_val;
  assign bus2.i_lock = lock;       assign bus3.i_lock = lock;       assign bus4.i_lock = lock;

  multi_sel_mode_ctrl #(.NCH(4), .NSTATE(2), .SW_SYNC(SWS)) dut2 (.clk(clk), .rst(rst), .s_if(bus2));
  multi_sel_mode_ctrl #(.NCH(4), .NSTATE(3), .SW_SYNC(SWS)) dut3 (.clk(clk), .rst(rst), .s_if(bus3));
  multi_sel_mode_ctrl #(.NCH(4), .NSTATE(4), .SW_SYNC(SWS)) dut4 (.clk(clk), .rst(rst), .s_if(bus4));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Reference: an edge on switch level history at edge k counts at update edge k+SWS+1,
  // unless k falls inside the first two post-reset samples; steps count one edge late.
  always @(posedge clk) begin : model
    exp_t       e;
    logic [3:0] sw_ev;
    logic [3:0] a;
    logic [3:0] b;
    int         m;
    int         k;
    int         vt;
    bit         ok;
    if (rst) begin
      sw_hist.delete();
      sw_hist.push_back(4'b0000);
      prev_step = '0;
      for (int j = 0; j < 3; j++) begin
        for (int c = 0; c < 4; c++) msel[j][c] = 0;
        e.sel[j] = 0;
        e.chg[j] = 0;
        e.err[j] = 0;
      end
    end else begin
      sw_hist.push_back(sw_lvl);
      m = sw_hist.size() - 1;
      k = m - SWS - 1;
      sw_ev = '0;
      if (k >= 2) begin
        a = sw_hist[k];
        b = sw_hist[k-1];
        sw_ev = a ^ b;
      end
      for (int j = 0; j < 3; j++) begin
        e.chg[j] = 0;
        vt = int'(pc_val) % (1 << w_tab[j]);
        ok = pc_load && (vt < ns_tab[j]);
        e.err[j] = (pc_load && !ok) ? 1 : 0;
        for (int c = 0; c < 4; c++) begin
          if (ok && int'(pc_ch) == c) begin
            if (msel[j][c] != vt) e.chg[j] |= (1 << c);
            msel[j][c] = vt;
          end else if ((sw_ev[c] || prev_step[c]) && !lock[c]) begin
            msel[j][c] = (msel[j][c] + 1) % ns_tab[j];
            e.chg[j] |= (1 << c);
          end
        end
        e.sel[j] = 0;
        for (int c = 0; c < 4; c++) e.sel[j] += msel[j][c] << (c * w_tab[j]);
      end
      prev_step = pc_step;
    end
    q.push_back(e);
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("ns2 sel", int'(bus2.o_sel), e.sel[0]);
      chk("ns2 chg", int'(bus2.o_chg), e.chg[0]);
      chk("ns2 err", int'(bus2.o_load_err), e.err[0]);
      chk("ns3 sel", int'(bus3.o_sel), e.sel[1]);
      chk("ns3 chg", int'(bus3.o_chg), e.chg[1]);
      chk("ns3 err", int'(bus3.o_load_err), e.err[1]);
      chk("ns4 sel", int'(bus4.o_sel), e.sel[2]);
      chk("ns4 chg", int'(bus4.o_chg), e.chg[2]);
      chk("ns4 err", int'(bus4.o_load_err), e.err[2]);
    end
  end

  task automatic rand_cycles(input int n);
    int bsel;
    repeat (n) begin
      if ($urandom_range(0, 5) == 0) begin
        bsel = $urandom_range(0, 3);
        sw_lvl[bsel] = ~sw_lvl[bsel];
      end
      pc_step = 4'($urandom) & 4'($urandom) & 4'($urandom);
      pc_load = ($urandom_range(0, 7) == 0);
      pc_ch   = ch_idx_t'($urandom);
      pc_val  = 2'($urandom);
      if ($urandom_range(0, 15) == 0) lock = 4'($urandom);
      tick(1);
    end
    pc_step = '0;
    pc_load = 1'b0;
  endtask

  initial begin
    sw_lvl  = 4'b0101;
    pc_step = '0;
    lock    = '0;
    pc_load = 1'b0;
    pc_ch   = '0;
    pc_val  = '0;
    rst     = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(22);

    sw_lvl = 4'b0000;
    tick(8);
    sw_lvl[0] = 1'b1;
    tick(8);
    sw_lvl[0] = 1'b0;
    tick(8);

    repeat (4) begin
      pc_step[2] = 1'b1;
      tick(1);
      pc_step[2] = 1'b0;
      tick(3);
    end

    sw_lvl[1] = 1'b1;
    tick(SWS);
    pc_step[1] = 1'b1;
    tick(1);
    pc_step[1] = 1'b0;
    tick(8);

    lock[3] = 1'b1;
    tick(1);
    pc_step[3] = 1'b1;
    tick(1);
    pc_step[3] = 1'b0;
    sw_lvl[3] = 1'b1;
    tick(8);
    pc_load = 1'b1; pc_ch = 2'd3; pc_val = 2'd2;
    tick(1);
    pc_load = 1'b0;
    tick(3);
    lock[3] = 1'b0;
    tick(8);

    pc_load = 1'b1; pc_ch = 2'd0; pc_val = 2'd3;
    tick(1);
    pc_load = 1'b0;
    tick(4);

    rand_cycles(500);

    sw_lvl = sw_lvl ^ 4'b1010;
    tick(1);
    rst = 1'b1;
    #1;
    chk("rst sel2", int'(bus2.o_sel), 0);
    chk("rst sel3", int'(bus3.o_sel), 0);
    chk("rst sel4", int'(bus4.o_sel), 0);
    chk("rst chg2", int'(bus2.o_chg), 0);
    chk("rst chg3", int'(bus3.o_chg), 0);
    chk("rst chg4", int'(bus4.o_chg), 0);
    chk("rst err2", int'(bus2.o_load_err), 0);
    chk("rst err3", int'(bus3.o_load_err), 0);
    chk("rst err4", int'(bus4.o_load_err), 0);
    tick(2);
    rst = 1'b0;
    tick(30);

    rand_cycles(300);
    tick(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
